// File: rtl/perceptron_trainer_pkg.sv
// Shared definitions for the perceptron trainer: Q4.12 format, FSM states and
// the 17-bit to 16-bit saturation helper.
package perceptron_trainer_pkg;

  localparam int unsigned QW = 16;
  localparam logic signed [QW-1:0] ONE = 16'sd4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_REQ,
    ST_SETTLE,
    ST_EVAL,
    ST_UPDATE,
    ST_NEXT,
    ST_FIN
  } state_t;

  function automatic logic signed [QW-1:0] sat16(input logic signed [QW:0] v);
    if (v > 17'sd32767) begin
      return 16'sh7fff;
    end else if (v < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[QW-1:0];
    end
  endfunction

endpackage

// File: rtl/perceptron_trainer_weight_update.sv
// Combinational perceptron learning rule for one weight:
// w_new = sat16(w +/- (x >>> LR_SHIFT)) depending on target/result disagreement.
module perceptron_trainer_weight_update
  import perceptron_trainer_pkg::*;
#(
  parameter int unsigned LR_SHIFT = 2
) (
  input  logic signed [QW-1:0] w,
  input  logic signed [QW-1:0] x,
  input  logic                 target,
  input  logic                 y,
  output logic signed [QW-1:0] w_new
);

  logic signed [QW:0] x_ext;
  logic signed [QW:0] w_ext;
  logic signed [QW:0] d;
  logic signed [QW:0] sum;

  // Step is computed in 17 bits so the add/subtract cannot wrap before saturation.
  always_comb begin
    x_ext = {x[QW-1], x};
    w_ext = {w[QW-1], w};
    d     = x_ext >>> LR_SHIFT;
    sum   = w_ext;
    if (target && !y) begin
      sum = w_ext + d;
    end else if (!target && y) begin
      sum = w_ext - d;
    end
    w_new = sat16(sum);
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Online trainer for a 2-input perceptron: loads initial weights, streams
// labelled samples through the perceptron and applies the learning rule on
// every misclassification until an error-free epoch or the epoch limit.
module perceptron_trainer
  import perceptron_trainer_pkg::*;
#(
  parameter int unsigned N_SAMPLES     = 4,
  parameter int unsigned MAX_EPOCHS    = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LR_SHIFT      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [QW-1:0] init_w1,
  input  logic signed [QW-1:0] init_w2,
  input  logic                 smp_valid,
  output logic                 smp_ready,
  input  logic signed [QW-1:0] smp_x1,
  input  logic signed [QW-1:0] smp_x2,
  input  logic                 smp_target,
  output logic signed [QW-1:0] p_in1,
  output logic signed [QW-1:0] p_in2,
  output logic signed [QW-1:0] p_w1_new,
  output logic signed [QW-1:0] p_w2_new,
  output logic                 p_w1_ld,
  output logic                 p_w2_ld,
  input  logic signed [QW-1:0] p_w1,
  input  logic signed [QW-1:0] p_w2,
  input  logic                 p_result,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [4:0]           epoch_count,
  output logic [7:0]           err_count
);

  localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t               state;
  state_t               state_next;
  logic [IW-1:0]        idx;
  logic [SW-1:0]        settle_cnt;
  logic signed [QW-1:0] x1_q;
  logic signed [QW-1:0] x2_q;
  logic                 tgt_q;
  logic                 y_q;
  logic                 last_smp;
  logic                 settle_end;
  logic signed [QW-1:0] w1_upd;
  logic signed [QW-1:0] w2_upd;

  assign p_in1      = x1_q;
  assign p_in2      = x2_q;
  assign last_smp   = (idx == IW'(N_SAMPLES - 1));
  assign settle_end = (settle_cnt == SW'(SETTLE_CYCLES - 1));

  perceptron_trainer_weight_update #(.LR_SHIFT(LR_SHIFT)) u_upd_w1 (
    .w(p_w1), .x(x1_q), .target(tgt_q), .y(y_q), .w_new(w1_upd)
  );

  perceptron_trainer_weight_update #(.LR_SHIFT(LR_SHIFT)) u_upd_w2 (
    .w(p_w2), .x(x2_q), .target(tgt_q), .y(y_q), .w_new(w2_upd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state;
    smp_ready  = 1'b0;
    p_w1_new   = '0;
    p_w2_new   = '0;
    p_w1_ld    = 1'b0;
    p_w2_ld    = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_next = ST_INIT;
      ST_INIT: begin
        p_w1_new   = init_w1;
        p_w2_new   = init_w2;
        p_w1_ld    = 1'b1;
        p_w2_ld    = 1'b1;
        state_next = ST_REQ;
      end
      ST_REQ: begin
        smp_ready = 1'b1;
        if (smp_valid) state_next = ST_SETTLE;
      end
      ST_SETTLE: if (settle_end) state_next = ST_EVAL;
      ST_EVAL:   state_next = (y_q == tgt_q) ? ST_NEXT : ST_UPDATE;
      ST_UPDATE: begin
        p_w1_new   = w1_upd;
        p_w2_new   = w2_upd;
        p_w1_ld    = 1'b1;
        p_w2_ld    = 1'b1;
        state_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (!last_smp) begin
          state_next = ST_REQ;
        end else if (err_count == '0) begin
          state_next = ST_FIN;
        end else if (epoch_count == 5'(MAX_EPOCHS - 1)) begin
          state_next = ST_FIN;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sample latches, settle timer, sample index and run statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      settle_cnt  <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      tgt_q       <= 1'b0;
      y_q         <= 1'b0;
      converged   <= 1'b0;
      epoch_count <= '0;
      err_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            converged   <= 1'b0;
            epoch_count <= '0;
            err_count   <= '0;
            idx         <= '0;
          end
        end
        ST_REQ: begin
          if (smp_valid) begin
            x1_q       <= smp_x1;
            x2_q       <= smp_x2;
            tgt_q      <= smp_target;
            settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_end) begin
            y_q <= p_result;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_EVAL: begin
          if ((y_q != tgt_q) && (err_count != 8'hff)) begin
            err_count <= err_count + 8'd1;
          end
        end
        ST_NEXT: begin
          if (!last_smp) begin
            idx <= idx + 1'b1;
          end else begin
            epoch_count <= epoch_count + 5'd1;
            if (err_count == '0) begin
              converged <= 1'b1;
            end else if (epoch_count != 5'(MAX_EPOCHS - 1)) begin
              err_count <= '0;
              idx       <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
